// File: rtl/csa_pkg.sv
// csa_pkg: shared helpers for the pipelined carry-skip adder (group count, popcount).
package csa_pkg;
   localparam int MAX_GROUPS = 256;
   function automatic int num_groups(input int width, input int block);
      return width / block;
   endfunction
   function automatic logic [31:0] popcount(input logic [MAX_GROUPS-1:0] v);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < MAX_GROUPS; i++) n = n + 32'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/carry_skip_group.sv
// carry_skip_group: BLOCK-bit ripple adder whose carry-out bypasses the ripple when every bit propagates.
module carry_skip_group #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output logic             skip
);
   logic [BLOCK:0] c;
   always_comb begin
      c[0] = cin;
      sum = '0;
      for (int i = 0; i < BLOCK; i++) begin
         sum[i] = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
      end
   end
   assign skip = &(a ^ b);
   assign cout = skip ? cin : c[BLOCK];
endmodule

// File: rtl/carry_skip_adder_pipe.sv
// carry_skip_adder_pipe: WIDTH-bit carry-skip adder split into STAGES registered slices with valid/ready.
// Optional skip_count statistics port enabled by CARRY_SKIP_ADDER_PIPE_STATS_EN.
module carry_skip_adder_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH-1:0]                    a,
   input  logic [WIDTH-1:0]                    b,
   input  logic                                cin,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [WIDTH-1:0]                    sum,
   output logic                                cout,
   output logic                                ovf,
   output logic [num_groups(WIDTH, BLOCK)-1:0] skip_mask
`ifdef CARRY_SKIP_ADDER_PIPE_STATS_EN
   ,
   output logic [31:0]                         skip_count
`endif
);
   localparam int NG = num_groups(WIDTH, BLOCK);
   localparam int WS = WIDTH / STAGES;
   localparam int GS = WS / BLOCK;

   if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad
      $error("carry_skip_adder_pipe: WIDTH must be a multiple of STAGES*BLOCK");
   end

   // s holds finished sum bits below the current slice and untouched a bits above it
   typedef struct packed {
      logic             v;
      logic             c;
      logic [WIDTH-1:0] s;
      logic [WIDTH-1:0] b;
      logic [NG-1:0]    skip;
   } stage_t;

   stage_t q [STAGES];
   stage_t d [STAGES];
   logic   adv, ovf_d, ovf_q;

   assign adv      = out_ready || !q[STAGES-1].v;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_s
      stage_t         src, nx;
      logic [GS:0]    c;
      logic [WS-1:0]  s;
      logic [GS-1:0]  sk;
      if (k == 0) begin : g_first
         assign src = '{v: in_valid, c: cin, s: a, b: b, skip: '0};
      end else begin : g_next
         assign src = q[k-1];
      end
      assign c[0] = src.c;
      for (genvar g = 0; g < GS; g++) begin : g_g
         carry_skip_group #(.BLOCK(BLOCK)) u_grp (
            .a   (src.s[k*WS + g*BLOCK +: BLOCK]),
            .b   (src.b[k*WS + g*BLOCK +: BLOCK]),
            .cin (c[g]),
            .sum (s[g*BLOCK +: BLOCK]),
            .cout(c[g+1]),
            .skip(sk[g])
         );
      end
      always_comb begin
         nx = src;
         nx.s[k*WS +: WS] = s;
         nx.c = c[GS];
         nx.skip[k*GS +: GS] = sk;
      end
      assign d[k] = nx;
      if (k == STAGES - 1) begin : g_last
         assign ovf_d = (src.s[WIDTH-1] == src.b[WIDTH-1]) && (s[WS-1] != src.s[WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) q[i] <= '0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int i = 0; i < STAGES; i++) q[i] <= d[i];
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = q[STAGES-1].v;
   assign sum       = q[STAGES-1].s;
   assign cout      = q[STAGES-1].c;
   assign skip_mask = q[STAGES-1].skip;
   assign ovf       = ovf_q;

   logic unused_b;
   assign unused_b = ^q[STAGES-1].b;

`ifdef CARRY_SKIP_ADDER_PIPE_STATS_EN
   logic [32:0] cnt_sum;
   assign cnt_sum = {1'b0, skip_count} + {1'b0, popcount(MAX_GROUPS'(skip_mask))};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) skip_count <= '0;
      else if (out_valid && out_ready) skip_count <= cnt_sum[32] ? '1 : cnt_sum[31:0];
   end
`endif
endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// tb_carry_skip_adder_pipe: directed and streamed checks of the 16-bit, 2-stage carry-skip adder pipe.
module tb_carry_skip_adder_pipe;
   localparam int W = 16, BL = 4, ST = 2, NG = W / BL, NR = 300;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
   logic [W-1:0]  a, b, sum;
   logic [NG-1:0] skip_mask;
`ifdef CARRY_SKIP_ADDER_PIPE_STATS_EN
   logic [31:0]   skip_count;
`endif
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   carry_skip_adder_pipe #(.WIDTH(W), .BLOCK(BL), .STAGES(ST)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .skip_mask(skip_mask)
`ifdef CARRY_SKIP_ADDER_PIPE_STATS_EN
      , .skip_count(skip_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk(input logic v, input logic c, input logic o,
                                      input logic [NG-1:0] m, input logic [W-1:0] s);
      return {9'b0, v, c, o, m, s};
   endfunction

   function automatic logic [31:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W:0]    t;
      logic [W-1:0]  p;
      logic [NG-1:0] m;
      t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      p = x ^ y;
      for (int g = 0; g < NG; g++) m[g] = &p[g*BL +: BL];
      return pk(1'b1, t[W], (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]), m, t[W-1:0]);
   endfunction

   function automatic logic [31:0] observed();
      return pk(out_valid, cout, ovf, skip_mask, sum);
   endfunction

   typedef struct {
      logic [W-1:0]  a, b;
      logic          ci;
      logic [W-1:0]  s;
      logic          co, ov;
      logic [NG-1:0] m;
   } vec_t;

   vec_t dv [8] = '{
      '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0010},
      '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111},
      '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110},
      '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 4'b0000},
      '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000},
      '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b0000},
      '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111},
      '{16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 4'b0110}
   };

   logic [W-1:0] sa [4] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h7000};
   logic [W-1:0] sb [4] = '{16'h0002, 16'h0001, 16'h1111, 16'h7000};
   logic         sc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [W-1:0] se [4] = '{16'h0003, 16'h0000, 16'h2346, 16'hE000};

   initial begin
      int           sent, got, stalls, seen;
      logic         acc, was_stall;
      logic [W-1:0] held;
      logic [31:0]  q [$];
      logic [31:0]  e, pop_sum;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", observed(), 32'd0);
      check("reset_rdy", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         a = dv[i].a; b = dv[i].b; cin = dv[i].ci; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         check($sformatf("dir%0d_rdy", i), 32'(in_ready), 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check($sformatf("dir%0d_lat", i), 32'(out_valid), 32'd0);
         @(posedge clk); #1;
         check($sformatf("dir%0d", i), observed(), pk(1'b1, dv[i].co, dv[i].ov, dv[i].m, dv[i].s));
      end
      repeat (3) @(posedge clk);
      #1;
      check("drain", 32'(out_valid), 32'd0);

      sent = 0; got = 0; stalls = 0; was_stall = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         out_ready = !(cyc >= 3 && cyc < 6);
         in_valid = sent < 4;
         if (sent < 4) begin a = sa[sent]; b = sb[sent]; cin = sc[sent]; end
         #1;
         if (was_stall) check("strm_hold", 32'(sum), 32'(held));
         was_stall = !out_ready && out_valid;
         if (was_stall) begin
            check("strm_stall_rdy", 32'(in_ready), 32'd0);
            held = sum;
            stalls++;
         end
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            check($sformatf("strm%0d", got), 32'(sum), 32'(se[got < 4 ? got : 0]));
            got++;
         end
         @(posedge clk); #1;
         if (acc) sent++;
      end
      in_valid = 1'b0;
      check("strm_cnt", 32'(got), 32'd4);
      check("strm_stalls", 32'(stalls), 32'd3);
      repeat (3) @(posedge clk);
      #1;

      out_ready = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      @(posedge clk); #1;
      a = 16'h3333; b = 16'h4444;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async", observed(), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("rst_no_stale", 32'(seen), 32'd0);
      in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("post_rst_lat", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("post_rst_res", observed(), pk(1'b1, 1'b0, 1'b0, 4'b0010, 16'h0100));
      repeat (3) @(posedge clk);
      #1;

      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      sent = 0; got = 0; pop_sum = '0;
      for (int cyc = 0; cyc < 5000 && got < NR; cyc++) begin
         out_ready = $urandom_range(0, 3) != 0;
         if (!in_valid && sent < NR && $urandom_range(0, 4) != 0) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            in_valid = 1'b1;
         end
         #1;
         acc = in_valid && in_ready;
         if (acc) q.push_back(model(a, b, cin));
         if (out_valid && out_ready) begin
            e = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
            check($sformatf("rnd%0d", got), observed(), e);
            for (int g = 0; g < NG; g++) pop_sum = pop_sum + 32'(e[W + g]);
            got++;
         end
         @(posedge clk); #1;
         if (acc) begin in_valid = 1'b0; sent++; end
      end
      check("rnd_cnt", 32'(got), 32'(NR));
`ifdef CARRY_SKIP_ADDER_PIPE_STATS_EN
      check("skip_count", skip_count, pop_sum);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
